// File: rtl/int_ram_ctrl_if.sv
// Bundle of the channel-input, decoder-side and dual-bank RAM signals of int_ram_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface int_ram_ctrl_if #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    logic                  dec_start;
    logic                  dec_busy;
    logic                  dec_rd_en;
    logic [ADDR_WIDTH-1:0] dec_rd_addr;
    logic [DATA_WIDTH-1:0] dec_rd_data;
    logic                  dec_rd_valid;
    logic                  dec_done;

    logic [ADDR_WIDTH-1:0] ram_addr   [0:1];
    logic [DATA_WIDTH-1:0] ram_din    [0:1];
    logic [DATA_WIDTH-1:0] ram_dout   [0:1];
    logic                  ram_we     [0:1];
    logic                  ram_cs     [0:1];
    logic [1:0]            bank_state [0:1];

    modport slave (
        input  in_valid, in_data, dec_rd_en, dec_rd_addr, dec_done, ram_dout,
        output in_ready, dec_start, dec_busy, dec_rd_data, dec_rd_valid,
               ram_addr, ram_din, ram_we, ram_cs, bank_state
    );

    modport master (
        output in_valid, in_data, dec_rd_en, dec_rd_addr, dec_done, ram_dout,
        input  in_ready, dec_start, dec_busy, dec_rd_data, dec_rd_valid,
               ram_addr, ram_din, ram_we, ram_cs, bank_state
    );
endinterface

// File: rtl/int_ram_ctrl.sv
// Ping-pong intrinsic-LLR buffer: one bank loads channel LLRs while the other is
// owned by the decoder; full banks are handed over in load order.
module int_ram_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input logic          clk,
    input logic          rst_n,
    int_ram_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DECODING = 2'd3
    } bank_st_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    bank_st_t              bank_q [0:1];
    bank_st_t              bank_d [0:1];
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rv_q;
    logic                  rv_bank_q;

    logic                  load_open;
    logic                  accept;
    logic                  rd_acc;
    logic                  start;
    logic                  freed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= '0;
            rv_q      <= 1'b0;
            rv_bank_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            busy_q    <= busy_d;
            wr_addr_q <= wr_addr_d;
            rv_q      <= rd_acc;
            if (rd_acc) begin
                rv_bank_q <= rd_sel_q;
            end
        end
    end

    // Handover, release and accept always touch different banks, so applying
    // them in sequence never lets one overwrite another's effect.
    always_comb begin
        load_open = (bank_q[wr_sel_q] == EMPTY) || (bank_q[wr_sel_q] == FILLING);
        accept    = bus.in_valid & rst_n & load_open;
        rd_acc    = bus.dec_rd_en & busy_q;
        start     = ~busy_q & (bank_q[rd_sel_q] == FULL);
        freed     = bus.dec_done & busy_q;

        bank_d    = bank_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        busy_d    = busy_q;
        wr_addr_d = wr_addr_q;

        if (start) begin
            bank_d[rd_sel_q] = DECODING;
            busy_d           = 1'b1;
        end
        if (freed) begin
            bank_d[rd_sel_q] = EMPTY;
            rd_sel_d         = ~rd_sel_q;
            busy_d           = 1'b0;
        end
        if (accept) begin
            if (wr_addr_q == LAST_ADDR) begin
                bank_d[wr_sel_q] = FULL;
                wr_addr_d        = '0;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                bank_d[wr_sel_q] = FILLING;
                wr_addr_d        = wr_addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready     = rst_n & load_open;
        bus.dec_start    = start;
        bus.dec_busy     = busy_q;
        bus.dec_rd_valid = rv_q;
        bus.dec_rd_data  = rv_q ? bus.ram_dout[rv_bank_q] : '0;

        for (int unsigned b = 0; b < 2; b++) begin
            bus.ram_cs[b]     = 1'b0;
            bus.ram_we[b]     = 1'b0;
            bus.ram_addr[b]   = '0;
            bus.ram_din[b]    = '0;
            bus.bank_state[b] = bank_q[b];
            if (accept && (wr_sel_q == b[0])) begin
                bus.ram_cs[b]   = 1'b1;
                bus.ram_we[b]   = 1'b1;
                bus.ram_addr[b] = wr_addr_q;
                bus.ram_din[b]  = bus.in_data;
            end else if (rd_acc && (rd_sel_q == b[0])) begin
                bus.ram_cs[b]   = 1'b1;
                bus.ram_addr[b] = bus.dec_rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_int_ram_ctrl.sv
// Bench for int_ram_ctrl: directed scenarios plus random traffic, checked each cycle
// against a frame-level model (fill pointer, queue of full banks, decoding bank).
module tb_int_ram_ctrl;

    localparam int DW = 5;
    localparam int AW = 8;
    localparam int FL = 256;

    logic clk = 1'b0;
    logic rst_n;

    int_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    int_ram_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FRAME_LEN (FL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Two synchronous single-port RAMs with one-cycle read latency.
    logic [DW-1:0] ram_mem [0:1][0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bus.ram_cs[b]) begin
                if (bus.ram_we[b]) ram_mem[b][bus.ram_addr[b]] <= bus.ram_din[b];
                else               bus.ram_dout[b] <= ram_mem[b][bus.ram_addr[b]];
            end
        end
    end

    // Reference model: which bank is loading and how far, banks waiting for the
    // decoder in arrival order, and which bank (if any) the decoder holds.
    int            m_fill;
    int            m_count;
    int            m_dec;
    int            full_q[$];
    logic [DW-1:0] m_mem [0:1][0:FL-1];
    bit            exp_rv;
    logic [DW-1:0] exp_rd;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_state(input int b);
        if (m_dec == b) return 3;
        foreach (full_q[i]) if (full_q[i] == b) return 2;
        if (m_fill == b && m_count > 0) return 1;
        return 0;
    endfunction

    function automatic bit exp_ready();
        return rst_n === 1'b1 && exp_state(m_fill) < 2;
    endfunction

    task automatic model_reset();
        m_fill  = 0;
        m_count = 0;
        m_dec   = -1;
        full_q.delete();
        exp_rv  = 1'b0;
        exp_rd  = '0;
    endtask

    task automatic check_outputs();
        bit acc, rd;
        acc = bus.in_valid && exp_ready();
        rd  = bus.dec_rd_en && m_dec >= 0;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        chk("dec_start", 32'(bus.dec_start), 32'(m_dec < 0 && full_q.size() > 0));
        chk("dec_busy", 32'(bus.dec_busy), 32'(m_dec >= 0));
        chk("dec_rd_valid", 32'(bus.dec_rd_valid), 32'(exp_rv));
        if (exp_rv) chk("dec_rd_data", 32'(bus.dec_rd_data), 32'(exp_rd));
        if (!rst_n) chk("dec_rd_data_rst", 32'(bus.dec_rd_data), 32'(0));
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("bank_state[%0d]", b), 32'(bus.bank_state[b]), exp_state(b));
            if (acc && m_fill == b) begin
                chk($sformatf("ram_cs[%0d]", b), 32'(bus.ram_cs[b]), 32'(1));
                chk($sformatf("ram_we[%0d]", b), 32'(bus.ram_we[b]), 32'(1));
                chk($sformatf("ram_addr[%0d]", b), 32'(bus.ram_addr[b]), m_count);
                chk($sformatf("ram_din[%0d]", b), 32'(bus.ram_din[b]), 32'(bus.in_data));
            end else if (rd && m_dec == b) begin
                chk($sformatf("ram_cs[%0d]", b), 32'(bus.ram_cs[b]), 32'(1));
                chk($sformatf("ram_we[%0d]", b), 32'(bus.ram_we[b]), 32'(0));
                chk($sformatf("ram_addr[%0d]", b), 32'(bus.ram_addr[b]), 32'(bus.dec_rd_addr));
            end else begin
                chk($sformatf("ram_cs[%0d]", b), 32'(bus.ram_cs[b]), 32'(0));
                chk($sformatf("ram_we[%0d]", b), 32'(bus.ram_we[b]), 32'(0));
                chk($sformatf("ram_addr[%0d]", b), 32'(bus.ram_addr[b]), 32'(0));
                chk($sformatf("ram_din[%0d]", b), 32'(bus.ram_din[b]), 32'(0));
            end
        end
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit acc, rd, dn, st;
        logic [DW-1:0] data;
        logic [AW-1:0] raddr;
        @(negedge clk);
        check_outputs();
        acc   = bus.in_valid && exp_ready();
        rd    = bus.dec_rd_en && m_dec >= 0;
        dn    = bus.dec_done && m_dec >= 0;
        st    = m_dec < 0 && full_q.size() > 0;
        data  = bus.in_data;
        raddr = bus.dec_rd_addr;
        @(posedge clk);
        if (rst_n) begin
            exp_rv = rd;
            if (rd) exp_rd = m_mem[m_dec][raddr];
            if (st) m_dec = full_q.pop_front();
            if (dn) m_dec = -1;
            if (acc) begin
                m_mem[m_fill][m_count] = data;
                m_count++;
                if (m_count == FL) begin
                    full_q.push_back(m_fill);
                    m_fill  = 1 - m_fill;
                    m_count = 0;
                end
            end
        end
        #1;
    endtask

    task automatic load(input int n, input bit done_last, input bit addr_pattern);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = addr_pattern ? DW'(m_count) : DW'($urandom);
            bus.dec_done = done_last && (i == n - 1);
            step();
        end
        bus.in_valid = 1'b0;
        bus.dec_done = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_dec_busy", 32'(bus.dec_busy), 32'(0));
        chk("rst_dec_rd_valid", 32'(bus.dec_rd_valid), 32'(0));
        chk("rst_bank0", 32'(bus.bank_state[0]), 32'(0));
        chk("rst_bank1", 32'(bus.bank_state[1]), 32'(0));
        repeat (n) step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.dec_rd_en   = 1'b0;
        bus.dec_rd_addr = '0;
        bus.dec_done    = 1'b0;
        bus.ram_dout[0] = '0;
        bus.ram_dout[1] = '0;
        do_reset(3);

        // One full frame of addr[4:0] values into bank 0, then hand-over.
        load(FL, 1'b0, 1'b1);
        chk("f0_bank0_full", 32'(bus.bank_state[0]), 32'(2));
        chk("f0_in_ready", 32'(bus.in_ready), 32'(1));
        chk("f0_dec_start", 32'(bus.dec_start), 32'(1));
        step();
        chk("f0_start_one_cycle", 32'(bus.dec_start), 32'(0));
        chk("f0_bank0_decoding", 32'(bus.bank_state[0]), 32'(3));

        // Read address 5 from the decoding bank.
        bus.dec_rd_en   = 1'b1;
        bus.dec_rd_addr = AW'(5);
        step();
        bus.dec_rd_en = 1'b0;
        chk("rd5_valid", 32'(bus.dec_rd_valid), 32'(1));
        chk("rd5_data", 32'(bus.dec_rd_data), 32'(5));
        step();

        // Fill bank 1 with the decoder still busy: loading stalls.
        load(FL, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        repeat (3) step();
        chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
        chk("stall_bank0", 32'(bus.bank_state[0]), 32'(3));
        chk("stall_bank1", 32'(bus.bank_state[1]), 32'(2));
        bus.in_valid = 1'b0;
        bus.dec_done = 1'b1;
        step();
        bus.dec_done = 1'b0;
        chk("rel_bank0_empty", 32'(bus.bank_state[0]), 32'(0));
        chk("rel_dec_start", 32'(bus.dec_start), 32'(1));
        chk("rel_in_ready", 32'(bus.in_ready), 32'(1));
        step();

        // Final accept of bank 1 coincides with release of bank 0.
        load(FL, 1'b0, 1'b0);
        bus.dec_done = 1'b1;
        step();
        bus.dec_done = 1'b0;
        step();
        load(FL, 1'b1, 1'b0);
        chk("coinc_bank0", 32'(bus.bank_state[0]), 32'(0));
        chk("coinc_bank1", 32'(bus.bank_state[1]), 32'(2));
        chk("coinc_dec_start", 32'(bus.dec_start), 32'(1));
        chk("coinc_in_ready", 32'(bus.in_ready), 32'(1));
        step();

        // Release, then spurious dec_done / dec_rd_en while idle.
        bus.dec_done = 1'b1;
        step();
        bus.dec_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.dec_rd_addr = AW'($urandom_range(0, FL - 1));
            step();
        end
        bus.dec_done  = 1'b0;
        bus.dec_rd_en = 1'b0;
        chk("idle_busy", 32'(bus.dec_busy), 32'(0));
        chk("idle_rd_valid", 32'(bus.dec_rd_valid), 32'(0));
        chk("idle_bank0", 32'(bus.bank_state[0]), 32'(0));
        chk("idle_bank1", 32'(bus.bank_state[1]), 32'(0));

        // Reset at LLR 100 of frame 1 while frame 0 decodes.
        load(FL, 1'b0, 1'b0);
        step();
        bus.dec_rd_en = 1'b1;
        load(100, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        do_reset(3);
        bus.dec_rd_en = 1'b0;
        load(10, 1'b0, 1'b1);
        chk("rst_reload_bank0", 32'(bus.bank_state[0]), 32'(1));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid    = ($urandom_range(0, 9) < 7);
            bus.in_data     = DW'($urandom);
            bus.dec_rd_en   = $urandom_range(0, 1) == 1;
            bus.dec_rd_addr = AW'($urandom_range(0, FL - 1));
            bus.dec_done    = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.dec_rd_en = 1'b0;
        bus.dec_done  = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
